// File: rtl/pattern_player_xfill_pkg.sv
// Shared types for the non-scan pattern player: X-fill policy and player FSM states.
package pattern_pkg;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_ADJ  = 2'd2
    } fill_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // Encoding 3 is unused on the host side and behaves as zero-fill.
    function automatic fill_mode_e decode_fill(input logic [1:0] m);
        case (m)
            2'd1:    return FILL_ONE;
            2'd2:    return FILL_ADJ;
            default: return FILL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/pattern_player_xfill_if.sv
// Host-side configuration/control port of the pattern player.
interface pattern_player_xfill_if #(
    parameter int NIN  = 5,
    parameter int NOUT = 2,
    parameter int AW   = 4
);
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [NIN-1:0]  cfg_pi;
    logic [NIN-1:0]  cfg_care;
    logic [NOUT-1:0] cfg_xpct;
    logic [NOUT-1:0] cfg_mask;
    logic [AW-1:0]   cfg_last;
    logic [1:0]      fill_mode;
    logic            start;

    modport master (
        output cfg_we, cfg_addr, cfg_pi, cfg_care, cfg_xpct, cfg_mask,
               cfg_last, fill_mode, start
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_pi, cfg_care, cfg_xpct, cfg_mask,
               cfg_last, fill_mode, start
    );
endinterface

// File: rtl/pattern_player_xfill_xfill_unit.sv
// Combinational X-fill of a stimulus vector plus flip count against the current drive value.
module xfill_unit
    import pattern_pkg::*;
#(
    parameter int NIN = 5,
    parameter int PW  = 3
) (
    input  logic [NIN-1:0] pi,
    input  logic [NIN-1:0] care,
    input  fill_mode_e     mode,
    input  logic [NIN-1:0] cur,
    output logic [NIN-1:0] nxt,
    output logic [PW-1:0]  flips
);
    logic [NIN-1:0] fillv;

    always_comb begin
        case (mode)
            FILL_ONE: fillv = '1;
            FILL_ADJ: fillv = cur;
            default:  fillv = '0;
        endcase
        nxt   = (pi & care) | (fillv & ~care);
        flips = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            flips = flips + PW'(nxt[i] ^ cur[i]);
        end
    end
endmodule

// File: rtl/pattern_player_xfill.sv
// Plays stored non-scan patterns with on-the-fly X-fill, compares responses and
// reports pass/fail, first failing index and the stimulus toggle count.
module pattern_player_xfill
    import pattern_pkg::*;
#(
    parameter int NIN    = 5,
    parameter int NOUT   = 2,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_player_xfill_if.slave cfg,
    output logic [NIN-1:0]       dut_pi,
    input  logic [NOUT-1:0]      dut_po,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        pat_idx,
    output logic                 pat_fail,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 first_fail_valid,
    output logic [AW-1:0]        first_fail_idx,
    output logic [CNT_W-1:0]     toggle_count
);
    localparam int PW = $clog2(NIN + 1);
    localparam int SW = $clog2(SETTLE) + 1;
    localparam logic [31:0] LAST_MAX = 32'(DEPTH - 1);
    localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

    logic [NIN-1:0]  mem_pi   [DEPTH];
    logic [NIN-1:0]  mem_care [DEPTH];
    logic [NOUT-1:0] mem_xpct [DEPTH];
    logic [NOUT-1:0] mem_mask [DEPTH];

    state_e          state, state_n;
    logic [SW-1:0]   settle_cnt;
    logic [AW-1:0]   last_q;
    fill_mode_e      mode_q;
    logic [NIN-1:0]  cur_pi, cur_care;
    logic [NOUT-1:0] cur_xpct, cur_mask;

    logic [NIN-1:0]  fill_nxt;
    logic [PW-1:0]   flips;
    logic            fail;
    logic [31:0]     tog_sum;
    logic [AW-1:0]   last_clip;

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst && !busy && cfg.cfg_we) begin
            mem_pi[cfg.cfg_addr]   <= cfg.cfg_pi;
            mem_care[cfg.cfg_addr] <= cfg.cfg_care;
            mem_xpct[cfg.cfg_addr] <= cfg.cfg_xpct;
            mem_mask[cfg.cfg_addr] <= cfg.cfg_mask;
        end
    end

    xfill_unit #(.NIN(NIN), .PW(PW)) u_fill (
        .pi    (cur_pi),
        .care  (cur_care),
        .mode  (mode_q),
        .cur   (dut_pi),
        .nxt   (fill_nxt),
        .flips (flips)
    );

    always_comb begin
        fail      = |((dut_po ^ cur_xpct) & cur_mask);
        tog_sum   = 32'(toggle_count) + 32'(flips);
        last_clip = (32'(cfg.cfg_last) > LAST_MAX) ? AW'(LAST_MAX) : cfg.cfg_last;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (cfg.start) state_n = ST_FETCH;
            ST_FETCH:   state_n = ST_APPLY;
            ST_APPLY:   state_n = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == SW'(SETTLE - 1)) state_n = ST_CAPTURE;
            ST_CAPTURE: state_n = (pat_idx == last_q) ? ST_DONE : ST_FETCH;
            ST_DONE:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_pi           <= '0;
            done             <= 1'b0;
            pat_idx          <= '0;
            pat_fail         <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            toggle_count     <= '0;
            settle_cnt       <= '0;
            last_q           <= '0;
            mode_q           <= FILL_ZERO;
            cur_pi           <= '0;
            cur_care         <= '0;
            cur_xpct         <= '0;
            cur_mask         <= '0;
        end else begin
            pat_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // dut_pi is deliberately left alone so the first pattern fills
                    // and toggles against whatever the previous run left driven.
                    if (cfg.start) begin
                        done             <= 1'b0;
                        pat_idx          <= '0;
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                        toggle_count     <= '0;
                        last_q           <= last_clip;
                        mode_q           <= decode_fill(cfg.fill_mode);
                    end
                end
                ST_FETCH: begin
                    cur_pi     <= mem_pi[pat_idx];
                    cur_care   <= mem_care[pat_idx];
                    cur_xpct   <= mem_xpct[pat_idx];
                    cur_mask   <= mem_mask[pat_idx];
                    settle_cnt <= '0;
                end
                ST_APPLY: begin
                    dut_pi       <= fill_nxt;
                    toggle_count <= (tog_sum > CNT_MAX) ? '1 : CNT_W'(tog_sum);
                end
                ST_SETTLE: settle_cnt <= settle_cnt + SW'(1);
                ST_CAPTURE: begin
                    if (fail) begin
                        pat_fail <= 1'b1;
                        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= pat_idx;
                        end
                    end
                    if (pat_idx == last_q) done <= 1'b1;
                    else                   pat_idx <= pat_idx + AW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_player_xfill.sv
// Randomized self-checking bench for pattern_player_xfill against a per-bit reference model.
module tb_pattern_player_xfill;
    localparam int NIN = 5, NOUT = 2, DEPTH = 16, SETTLE = 2, AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_player_xfill_if #(.NIN(NIN), .NOUT(NOUT), .AW(AW)) cfg_bus ();

    logic [NIN-1:0]  dut_pi, dut_pi_s;
    logic [NOUT-1:0] dut_po, dut_po_s;
    logic            busy, done, pat_fail, first_fail_valid;
    logic [AW-1:0]   pat_idx, first_fail_idx;
    logic [15:0]     fail_count, toggle_count;
    logic            busy_s, done_s, pat_fail_s, first_fail_valid_s;
    logic [AW-1:0]   pat_idx_s, first_fail_idx_s;
    logic [1:0]      fail_count_s, toggle_count_s;

    pattern_player_xfill #(.NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg(cfg_bus), .dut_pi(dut_pi), .dut_po(dut_po),
        .busy(busy), .done(done), .pat_idx(pat_idx), .pat_fail(pat_fail),
        .fail_count(fail_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .toggle_count(toggle_count)
    );

    // Narrow-counter copy sharing the same host port, used to exercise saturation.
    pattern_player_xfill #(.NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg(cfg_bus), .dut_pi(dut_pi_s), .dut_po(dut_po_s),
        .busy(busy_s), .done(done_s), .pat_idx(pat_idx_s), .pat_fail(pat_fail_s),
        .fail_count(fail_count_s), .first_fail_valid(first_fail_valid_s),
        .first_fail_idx(first_fail_idx_s), .toggle_count(toggle_count_s)
    );

    function automatic bit [1:0] blk(input bit [4:0] v);
        return {v[4] ^ v[1], v[1] & v[0]};
    endfunction

    always_comb dut_po   = blk(dut_pi);
    always_comb dut_po_s = blk(dut_pi_s);

    int n_checks = 0, n_errors = 0;
    bit [4:0] m_pi [DEPTH], m_care [DEPTH];
    bit [1:0] m_xpct [DEPTH], m_mask [DEPTH];
    bit [4:0] mprev;

    bit [4:0] t2_pi  [3] = '{5'b10000, 5'b10111, 5'b10101};
    int       t2_tog [3] = '{4, 3, 2};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [4:0] ref_fill(input bit [4:0] pi, input bit [4:0] care,
                                          input int mode, input bit [4:0] prev);
        bit [4:0] r;
        for (int b = 0; b < 5; b++) begin
            if (care[b])        r[b] = pi[b];
            else if (mode == 1) r[b] = 1'b1;
            else if (mode == 2) r[b] = prev[b];
            else                r[b] = 1'b0;
        end
        return r;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic write_entry(input int a);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_addr = 4'(a);
        cfg_bus.cfg_pi   = m_pi[a];
        cfg_bus.cfg_care = m_care[a];
        cfg_bus.cfg_xpct = m_xpct[a];
        cfg_bus.cfg_mask = m_mask[a];
        @(posedge clk); #1;
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic set_entry(input int a, input bit [4:0] pi, input bit [4:0] care,
                             input bit [1:0] xp, input bit [1:0] mk);
        m_pi[a] = pi; m_care[a] = care; m_xpct[a] = xp; m_mask[a] = mk;
        write_entry(a);
    endtask

    // kind 0: random compare data, 1: failures only at 2 and 5, 2: every pattern fails
    task automatic gen_patterns(input int last, input int mode, input int kind);
        bit [4:0] p, e;
        p = mprev;
        for (int i = 0; i <= last; i++) begin
            m_pi[i]   = 5'($urandom);
            m_care[i] = 5'($urandom);
            e = ref_fill(m_pi[i], m_care[i], mode, p);
            p = e;
            case (kind)
                0: begin m_xpct[i] = 2'($urandom); m_mask[i] = 2'($urandom); end
                1: begin
                    if (i == 2 || i == 5) begin m_xpct[i] = ~blk(e); m_mask[i] = 2'b11; end
                    else begin m_xpct[i] = blk(e); m_mask[i] = 2'($urandom); end
                end
                default: begin m_xpct[i] = ~blk(e); m_mask[i] = 2'b11; end
            endcase
            write_entry(i);
        end
    endtask

    task automatic check_reset_state();
        check_val("rst_dut_pi", dut_pi, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pat_idx", pat_idx, 0);
        check_val("rst_pat_fail", pat_fail, 0);
        check_val("rst_fail_count", fail_count, 0);
        check_val("rst_ff_valid", first_fail_valid, 0);
        check_val("rst_ff_idx", first_fail_idx, 0);
        check_val("rst_toggle", toggle_count, 0);
        check_val("rst_sat_pi", dut_pi_s, 0);
        check_val("rst_sat_fc", fail_count_s, 0);
    endtask

    task automatic run_check(input int last, input int mode, input bit disturb);
        int exp_fc = 0, exp_tog = 0, exp_ffi = 0;
        bit exp_ffv = 0, f;
        bit [4:0] e;
        cfg_bus.cfg_last  = 4'(last);
        cfg_bus.fill_mode = 2'(mode);
        cfg_bus.start     = 1'b1;
        @(posedge clk); #1;
        cfg_bus.start     = 1'b0;
        for (int i = 0; i <= last; i++) begin
            e = ref_fill(m_pi[i], m_care[i], mode, mprev);
            exp_tog += $countones(e ^ mprev);
            mprev = e;
            f = |((blk(e) ^ m_xpct[i]) & m_mask[i]);
            repeat (2) @(posedge clk); #1;
            check_val("dut_pi", dut_pi, e);
            check_val("sat_dut_pi", dut_pi_s, e);
            check_val("pat_idx", pat_idx, i);
            check_val("busy", busy, 1);
            if (i == 0) check_val("done_cleared", done, 0);
            if (disturb && i == 1) begin
                cfg_bus.cfg_we    = 1'b1;
                cfg_bus.cfg_addr  = 4'($urandom_range(0, last));
                cfg_bus.cfg_pi    = 5'($urandom);
                cfg_bus.cfg_care  = 5'($urandom);
                cfg_bus.cfg_xpct  = 2'($urandom);
                cfg_bus.cfg_mask  = 2'($urandom);
                cfg_bus.cfg_last  = 4'($urandom);
                cfg_bus.fill_mode = 2'($urandom);
                cfg_bus.start     = 1'b1;
                @(posedge clk); #1;
                cfg_bus.cfg_we    = 1'b0;
                cfg_bus.start     = 1'b0;
                repeat (SETTLE) @(posedge clk);
            end else begin
                repeat (SETTLE + 1) @(posedge clk);
            end
            #1;
            check_val("pat_fail", pat_fail, f);
            if (f) begin
                exp_fc++;
                if (!exp_ffv) begin exp_ffv = 1; exp_ffi = i; end
            end
        end
        check_val("done", done, 1);
        check_val("busy_end", busy, 0);
        check_val("pat_idx_end", pat_idx, last);
        check_val("fail_count", fail_count, exp_fc);
        check_val("ff_valid", first_fail_valid, exp_ffv);
        if (exp_ffv) check_val("ff_idx", first_fail_idx, exp_ffi);
        check_val("toggle_count", toggle_count, exp_tog);
        check_val("sat_fail_count", fail_count_s, sat3(exp_fc));
        check_val("sat_toggle", toggle_count_s, sat3(exp_tog));
        @(posedge clk); #1;
        check_val("done_held", done, 1);
    endtask

    initial begin
        cfg_bus.cfg_we = 0; cfg_bus.cfg_addr = 0; cfg_bus.cfg_pi = 0; cfg_bus.cfg_care = 0;
        cfg_bus.cfg_xpct = 0; cfg_bus.cfg_mask = 0; cfg_bus.cfg_last = 0;
        cfg_bus.fill_mode = 0; cfg_bus.start = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        mprev = '0;
        check_reset_state();

        // Full-care single pattern, expected response matches
        set_entry(0, 5'b11101, 5'b11111, 2'b10, 2'b11);
        run_check(0, 0, 0);
        check_val("t1_pi", dut_pi, 5'b11101);
        check_val("t1_fc", fail_count, 0);

        // Each fill policy against a known previous drive value
        for (int m = 0; m < 3; m++) begin
            set_entry(0, 5'b01101, 5'b11111, 2'b00, 2'b00);
            run_check(0, 0, 0);
            set_entry(0, 5'b10000, 5'b11000, 2'b00, 2'b00);
            run_check(0, m, 0);
            check_val("t2_fill", dut_pi, t2_pi[m]);
            check_val("t2_tog", toggle_count, t2_tog[m]);
        end

        // Compare masking
        set_entry(0, 5'b11101, 5'b11111, 2'b10, 2'b11);
        set_entry(1, 5'b00000, 5'b11111, 2'b10, 2'b11);
        run_check(1, 0, 0);
        check_val("t3_fc", fail_count, 1);
        check_val("t3_ffi", first_fail_idx, 1);
        set_entry(1, 5'b00000, 5'b11111, 2'b10, 2'b01);
        run_check(1, 0, 0);
        check_val("t3_masked_fc", fail_count, 0);

        // Failures at 2 and 5 of 7
        gen_patterns(6, 2, 1);
        run_check(6, 2, 0);
        check_val("t4_fc", fail_count, 2);
        check_val("t4_ffi", first_fail_idx, 2);
        check_val("t4_idx", pat_idx, 6);

        // All 16 fail: narrow counters saturate
        gen_patterns(15, 1, 2);
        run_check(15, 1, 0);
        check_val("t6_fc16", fail_count, 16);
        check_val("t6_fc_sat", fail_count_s, 3);

        // Writes and starts while busy are dropped; a readback run uses original entries
        gen_patterns(9, 3, 0);
        run_check(9, 3, 1);
        run_check(9, 2, 0);

        // Reset during SETTLE of pattern 3, then rerun from 0
        gen_patterns(5, 2, 0);
        cfg_bus.cfg_last = 4'd5; cfg_bus.fill_mode = 2'd2; cfg_bus.start = 1'b1;
        @(posedge clk); #1;
        cfg_bus.start = 1'b0;
        repeat (3 * (SETTLE + 3) + 2) @(posedge clk); #1;
        check_val("t5_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state();
        mprev = '0;
        run_check(5, 2, 0);

        for (int r = 0; r < 4; r++) begin
            int last, mode;
            last = $urandom_range(0, DEPTH - 1);
            mode = $urandom_range(0, 3);
            gen_patterns(last, mode, 0);
            run_check(last, mode, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
